// File: rtl/frame_burst_sched.sv
// Frame-buffer burst scheduler: walks a frame in bursts of up to BURST_LEN words,
// requesting each burst only when the pixel FIFO can absorb it completely.
`timescale 1ns/1ps
module frame_burst_sched #(
    parameter int FIFO_ALMOSTFULL_DEPTH = 768,
    parameter int BURST_LEN             = 64,
    parameter int FRAME_WORDS           = 384000,
    parameter int BYTES_PER_WORD        = 4
) (
    input  logic        fifo_wr_clk,
    input  logic        rst_n,
    input  logic [31:0] frame_base_addr,
    input  logic        frame_start,
    input  logic [9:0]  fifo_wr_cnt,
    input  logic        fifo_full,
    output logic        fifo_clr,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [7:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_SPACE = 3'd1,
        S_REQ        = 3'd2,
        S_XFER       = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    localparam logic [10:0] AF_DEPTH   = 11'(FIFO_ALMOSTFULL_DEPTH);
    localparam logic [19:0] BURST_W    = 20'(BURST_LEN);
    localparam logic [19:0] FRAME_W    = 20'(FRAME_WORDS);
    localparam logic [31:0] WORD_BYTES = 32'(BYTES_PER_WORD);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [19:0] remain_q, remain_d;
    logic        pend_q, pend_d;

    logic [7:0]  len;
    logic [10:0] fill_after;
    logic        space_ok;
    logic [19:0] remain_next;
    logic        restart;

    assign len         = (remain_q < BURST_W) ? remain_q[7:0] : BURST_W[7:0];
    // 11-bit sum so a nearly full FIFO plus a burst cannot wrap past the limit
    assign fill_after  = {1'b0, fifo_wr_cnt} + {3'b000, len};
    assign space_ok    = !fifo_full && (fill_after <= AF_DEPTH);
    assign remain_next = remain_q - {12'd0, len};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        pend_d   = pend_q;
        restart  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) restart = 1'b1;
            end
            S_WAIT_SPACE: begin
                if (frame_start)   restart = 1'b1;
                else if (space_ok) state_d = S_REQ;
            end
            S_REQ: begin
                if (frame_start) pend_d  = 1'b1;
                if (rd_ack)      state_d = S_XFER;
            end
            S_XFER: begin
                if (rd_done) begin
                    // A restart requested mid-burst takes effect once the burst has landed
                    if (pend_q || frame_start) begin
                        restart = 1'b1;
                    end else begin
                        addr_d   = addr_q + 32'(len) * WORD_BYTES;
                        remain_d = remain_next;
                        state_d  = (remain_next == 20'd0) ? S_DONE : S_WAIT_SPACE;
                    end
                end else if (frame_start) begin
                    pend_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (frame_start) restart = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (restart) begin
            addr_d   = frame_base_addr;
            remain_d = FRAME_W;
            pend_d   = 1'b0;
            state_d  = S_WAIT_SPACE;
        end
    end

    always_ff @(posedge fifo_wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            remain_q <= 20'd0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            pend_q   <= pend_d;
        end
    end

    // fifo_clr follows frame_start combinationally, so gate it with reset as well
    assign fifo_clr    = restart && rst_n;
    assign rd_req      = (state_q == S_REQ);
    assign rd_addr     = addr_q;
    assign rd_len      = len;
    assign frame_busy  = (state_q == S_WAIT_SPACE) || (state_q == S_REQ) || (state_q == S_XFER);
    assign frame_done  = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_frame_burst_sched.sv
// Bench for frame_burst_sched: plays the memory reader and FIFO, and checks bursts
// against a burst plan computed from frame size, burst size and base address.
`timescale 1ns/1ps
module tb_frame_burst_sched;

    localparam int FW  = 100;
    localparam int BL  = 64;
    localparam int AF  = 768;
    localparam int BPW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] frame_base_addr;
    logic        frame_start;
    logic [9:0]  fifo_wr_cnt;
    logic        fifo_full;
    logic        fifo_clr;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_done;
    logic        frame_busy;
    logic        frame_done;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    frame_burst_sched #(
        .FIFO_ALMOSTFULL_DEPTH(AF),
        .BURST_LEN(BL),
        .FRAME_WORDS(FW),
        .BYTES_PER_WORD(BPW)
    ) dut (
        .fifo_wr_clk(clk),
        .rst_n(rst_n),
        .frame_base_addr(frame_base_addr),
        .frame_start(frame_start),
        .fifo_wr_cnt(fifo_wr_cnt),
        .fifo_full(fifo_full),
        .fifo_clr(fifo_clr),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_len(rd_len),
        .rd_ack(rd_ack),
        .rd_done(rd_done),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .dbg_state_o(dbg_state)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected burst list of a whole frame starting at base
    task automatic plan_frame(input logic [31:0] base);
        int off;
        int n;
        off = 0;
        exp_addr_q.delete();
        exp_len_q.delete();
        while (off < FW) begin
            n = (FW - off < BL) ? FW - off : BL;
            exp_addr_q.push_back(base + 32'(off * BPW));
            exp_len_q.push_back(8'(n));
            off += n;
        end
    endtask

    task automatic start_frame(input logic [31:0] base);
        frame_base_addr = base;
        frame_start = 1'b1;
        #1;
        check("clr_on_start", fifo_clr, 1);
        tick;
        frame_start = 1'b0;
        check("busy_after_start", frame_busy, 1);
        check("no_req_after_start", rd_req, 0);
        plan_frame(base);
    endtask

    // DUT is waiting for space; mode 1 replays the fixed stall sequence
    task automatic wait_grant(input int mode, output bit ok);
        int n;
        bit exp_req;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            if (mode == 1) begin
                if (n < 5)       begin fifo_wr_cnt = 10'd705; fifo_full = 1'b0; end
                else if (n < 10) begin fifo_wr_cnt = 10'd0;   fifo_full = 1'b1; end
                else             begin fifo_wr_cnt = 10'd704; fifo_full = 1'b0; end
            end else if (n >= 30) begin
                fifo_wr_cnt = 10'd0;
                fifo_full   = 1'b0;
            end else begin
                fifo_wr_cnt = 10'($urandom_range(600, 800));
                fifo_full   = ($urandom_range(0, 7) == 0);
            end
            exp_req = !fifo_full && (int'(fifo_wr_cnt) + int'(exp_len_q[0]) <= AF);
            tick;
            check("req_vs_space", rd_req, exp_req);
            ok = rd_req;
            n++;
        end
        if (!ok) check("grant_timeout", 0, 1);
    endtask

    task automatic serve_burst(input int ack_dly, input int done_dly);
        check("rd_addr", rd_addr, exp_addr_q[0]);
        check("rd_len", rd_len, exp_len_q[0]);
        for (int i = 0; i < ack_dly; i++) begin
            tick;
            check("hold_req", rd_req, 1);
            check("hold_addr", rd_addr, exp_addr_q[0]);
            check("hold_len", rd_len, exp_len_q[0]);
        end
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        check("req_drop_after_ack", rd_req, 0);
        check("busy_in_xfer", frame_busy, 1);
        for (int i = 0; i < done_dly; i++) tick;
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
        void'(exp_addr_q.pop_front());
        void'(exp_len_q.pop_front());
    endtask

    task automatic serve_rest(input int mode);
        bit ok;
        int m;
        m = mode;
        while (exp_addr_q.size() > 0) begin
            wait_grant(m, ok);
            if (!ok) break;
            serve_burst($urandom_range(0, 4), $urandom_range(0, 6));
            m = 0;
        end
    endtask

    task automatic finish_frame;
        check("frame_done_pulse", frame_done, 1);
        check("busy_low_in_done", frame_busy, 0);
        check("no_req_in_done", rd_req, 0);
        tick;
        check("frame_done_one_cycle", frame_done, 0);
        check("busy_low_idle", frame_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [31:0] base;
        rst_n = 1'b0;
        frame_base_addr = 32'hDEAD_BEEF;
        frame_start = 1'b0;
        fifo_wr_cnt = 10'd0;
        fifo_full = 1'b0;
        rd_ack = 1'b0;
        rd_done = 1'b0;
        #1;
        check("rst_fifo_clr", fifo_clr, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_len", rd_len, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_state", dbg_state, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick;

        // Nominal frame with the fixed stall sequence before the first burst
        start_frame(32'h1000_0000);
        serve_rest(1);
        finish_frame();

        // Long ack hold, then restart issued in DONE
        start_frame(32'h2000_0000);
        wait_grant(0, ok);
        if (ok) serve_burst(10, 2);
        serve_rest(0);
        check("done_before_restart", frame_done, 1);
        frame_base_addr = 32'h3000_0040;
        frame_start = 1'b1;
        #1;
        check("clr_restart_in_done", fifo_clr, 1);
        check("done_still_pulses", frame_done, 1);
        tick;
        frame_start = 1'b0;
        check("busy_after_done_restart", frame_busy, 1);
        check("no_done_after_restart", frame_done, 0);
        plan_frame(32'h3000_0040);
        serve_rest(0);
        finish_frame();

        // Restart while waiting for space
        start_frame(32'h3100_0000);
        fifo_wr_cnt = 10'd1023;
        fifo_full = 1'b1;
        tick;
        check("stall_full", rd_req, 0);
        frame_base_addr = 32'h3200_0100;
        frame_start = 1'b1;
        #1;
        check("clr_restart_wait", fifo_clr, 1);
        check("no_done_restart_wait", frame_done, 0);
        tick;
        frame_start = 1'b0;
        check("busy_restart_wait", frame_busy, 1);
        plan_frame(32'h3200_0100);
        serve_rest(0);
        finish_frame();

        // Restart during XFER, rd_done five cycles later
        start_frame(32'h4000_0000);
        wait_grant(0, ok);
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        frame_base_addr = 32'h5000_0000;
        frame_start = 1'b1;
        #1;
        check("no_clr_while_xfer", fifo_clr, 0);
        tick;
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("pend_no_clr", fifo_clr, 0);
            check("pend_no_done", frame_done, 0);
            check("pend_busy", frame_busy, 1);
            tick;
        end
        rd_done = 1'b1;
        #1;
        check("clr_on_rd_done", fifo_clr, 1);
        tick;
        rd_done = 1'b0;
        check("no_done_after_pend", frame_done, 0);
        check("busy_after_pend", frame_busy, 1);
        plan_frame(32'h5000_0000);
        serve_rest(0);
        finish_frame();

        // frame_start coincident with rd_done
        start_frame(32'h5800_0000);
        wait_grant(0, ok);
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        tick;
        frame_base_addr = 32'h5900_0200;
        frame_start = 1'b1;
        rd_done = 1'b1;
        #1;
        check("clr_coincident", fifo_clr, 1);
        tick;
        frame_start = 1'b0;
        rd_done = 1'b0;
        check("no_done_coincident", frame_done, 0);
        plan_frame(32'h5900_0200);
        serve_rest(0);
        finish_frame();

        // Asynchronous reset mid-XFER, stray handshakes afterwards ignored
        start_frame(32'h6000_0000);
        wait_grant(0, ok);
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_addr", rd_addr, 0);
        check("arst_rd_len", rd_len, 0);
        check("arst_rd_req", rd_req, 0);
        check("arst_busy", frame_busy, 0);
        check("arst_done", frame_done, 0);
        check("arst_clr", fifo_clr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_done = 1'b1;
        rd_ack = 1'b1;
        tick;
        rd_done = 1'b0;
        rd_ack = 1'b0;
        check("ignore_done_busy", frame_busy, 0);
        check("ignore_done_req", rd_req, 0);
        tick;
        check("ignore_done_frame_done", frame_done, 0);
        check("ignore_done_busy2", frame_busy, 0);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            base = $urandom & 32'hFFFF_FFFC;
            start_frame(base);
            serve_rest(0);
            finish_frame();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/frame_burst_sched.md
FRAME_BURST_SCHED -- requirements
Module: frame_burst_sched

Interface
REQ-001 SHALL have parameter FIFO_ALMOSTFULL_DEPTH, default 768, max fill level the FIFO may reach once a granted burst has fully landed.
REQ-002 SHALL have parameter BURST_LEN, default 64, words per full burst, legal range 1..255.
REQ-003 SHALL have parameter FRAME_WORDS, default 384000, 32-bit words per frame (800x480), legal range 1..2^20-1.
REQ-004 SHALL have parameter BYTES_PER_WORD, default 4, address increment per word.
REQ-005 SHALL have port fifo_wr_clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port frame_base_addr  in  32  frame buffer byte base address, sampled on frame_start.
REQ-008 SHALL have port frame_start  in  1  single-cycle pulse, already synchronous to fifo_wr_clk; starts or restarts a frame.
REQ-009 SHALL have port fifo_wr_cnt  in  10  pixel FIFO fill count.
REQ-010 SHALL have port fifo_full  in  1  pixel FIFO full flag.
REQ-011 SHALL have port fifo_clr  out  1  one-cycle FIFO flush pulse.
REQ-012 SHALL have port rd_req  out  1  burst read request to the memory reader.
REQ-013 SHALL have port rd_addr  out  32  burst start byte address.
REQ-014 SHALL have port rd_len  out  8  burst length in words.
REQ-015 SHALL have port rd_ack  in  1  reader accepted the request.
REQ-016 SHALL have port rd_done  in  1  one-cycle pulse: last word of the accepted burst written to FIFO.
REQ-017 SHALL have port frame_busy  out  1  high from frame start until frame completion.
REQ-018 SHALL have port frame_done  out  1  one-cycle pulse on frame completion.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_SPACE, REQ, XFER, DONE.
REQ-020 SHALL, in IDLE on frame_start: latch addr=frame_base_addr, remain=FRAME_WORDS (20-bit), pulse fifo_clr for 1 cycle, go to WAIT_SPACE.
REQ-021 SHALL compute len = min(BURST_LEN, remain) combinationally from registered remain.
REQ-022 SHALL, in WAIT_SPACE, go to REQ when fifo_full==0 and fifo_wr_cnt+len <= FIFO_ALMOSTFULL_DEPTH, with the sum evaluated at 11 bits so it cannot wrap.
REQ-023 SHALL drive rd_req=1, rd_addr=addr and rd_len=len in REQ, holding all three stable until rd_ack; on rd_ack, go to XFER the next cycle.
REQ-024 SHALL drive rd_req=0 in every state except REQ.
REQ-025 SHALL, in XFER on rd_done: addr += len*BYTES_PER_WORD (32-bit wrap), remain -= len; go to DONE if the new remain==0, else WAIT_SPACE.
REQ-026 SHALL, in DONE: assert frame_done for exactly that cycle, then go to IDLE.
REQ-027 SHALL drive frame_busy=1 in WAIT_SPACE, REQ and XFER, and 0 in IDLE and DONE.
REQ-028 SHALL treat frame_start in WAIT_SPACE as an immediate restart with the REQ-020 actions, and SHALL NOT pulse frame_done.
REQ-029 SHALL, on frame_start in REQ or XFER, set a restart_pend flag and keep the outstanding handshake: REQ completes on rd_ack, XFER waits for rd_done.
REQ-030 SHALL, on rd_done with restart_pend set, clear restart_pend and perform the REQ-020 actions instead of REQ-025; no frame_done is pulsed.
REQ-031 SHALL give frame_start coincident with rd_done in XFER the REQ-030 behaviour.
REQ-032 SHALL perform the REQ-020 actions on frame_start in DONE; frame_done still pulses that cycle.
REQ-033 SHALL make the last burst of a frame short when remain < BURST_LEN, e.g. 384000 mod 64 = 0, and FRAME_WORDS=100 gives bursts 64 then 36.

Reset
REQ-034 SHALL, while rst_n is low, asynchronously force: state=IDLE, addr=0, remain=0, restart_pend=0, fifo_clr=0, rd_req=0, rd_addr=0, rd_len=0, frame_busy=0, frame_done=0.
REQ-035 SHALL abandon any outstanding burst when rst_n is asserted mid-frame, and SHALL ignore rd_done/rd_ack received in IDLE.

Verification
REQ-036 SHALL pass a nominal frame: FRAME_WORDS=128, base 0x1000_0000, fifo_wr_cnt=0, immediate ack/done -> two requests at 0x1000_0000 and 0x1000_0100 with len 64, then one frame_done pulse.
REQ-037 SHALL pass a space stall: fifo_wr_cnt=705 -> no rd_req; fifo_wr_cnt=704 -> rd_req on the next cycle; fifo_full=1 with cnt 0 -> no rd_req.
REQ-038 SHALL pass a short tail: FRAME_WORDS=100 -> rd_len 64 then 36, second rd_addr = base+256.
REQ-039 SHALL pass a handshake hold: rd_ack withheld 10 cycles -> rd_req, rd_addr and rd_len remain constant for all 10 cycles.
REQ-040 SHALL pass a restart: frame_start during XFER followed by rd_done 5 cycles later -> fifo_clr pulse on the rd_done cycle, addr reloaded, no frame_done.
REQ-041 SHALL pass a reset: rst_n low mid-XFER -> all outputs 0 without a clock edge; rd_done after release is ignored.
